// File: rtl/fir_mac.sv
// fir_mac: sequential single-multiplier FIR filter.
// Computes y[n] = (sum_{k=0..NTAPS-1} c[k] * x[n-k]) * 2^-FRAC with one
// multiply-accumulate per cycle, then scales and saturates to DATA_W bits.
//
// Optional feature macro: FIR_MAC_ROUND_EN
//   defined   -> round half up (add 2^(FRAC-1) before the shift)
//   undefined -> truncate toward negative infinity (plain arithmetic shift)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   sample offered
//   in_ready   block accepts a sample this cycle (IDLE only)
//   in_data    signed sample x[n]
//   coef_we    coefficient write strobe (honoured in IDLE only)
//   coef_addr  tap index k
//   coef_wdata signed coefficient c[k]
//   out_valid  result y[n] available
//   out_ready  consumer accepts the result
//   out_data   signed result y[n]
//   busy       high in every state except IDLE
module fir_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned FRAC   = 14,
    parameter int unsigned NTAPS  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       busy
);

    localparam int unsigned AW    = $clog2(NTAPS);
    localparam int unsigned AW1   = AW + 1;
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam int unsigned ACC_W = PW + AW;
    // One spare bit so the rounding offset can never wrap the accumulator
    localparam int unsigned SW    = ACC_W + 1;

    localparam logic signed [SW-1:0] OMAX = SW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

`ifdef FIR_MAC_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(64'sd1 <<< (FRAC - 1));
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;

    logic signed [DATA_W-1:0] dline [NTAPS];
    logic signed [COEF_W-1:0] coef  [NTAPS];

    logic [AW-1:0]            wr_ptr;   // slot for the next incoming sample
    logic [AW-1:0]            base;     // slot holding x[n] for this result
    logic [AW-1:0]            tap;      // current k during MAC
    logic [AW-1:0]            rd_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PW-1:0]     product;
    logic signed [SW-1:0]     rounded;
    logic signed [SW-1:0]     shifted;
    logic signed [DATA_W-1:0] sat_data;

    // Delay-line slot of x[n-k], wrapping modulo NTAPS
    always_comb begin
        rd_idx = '0;
        if (base >= tap) begin
            rd_idx = base - tap;
        end else begin
            rd_idx = AW'(AW1'(base) + AW1'(NTAPS) - AW1'(tap));
        end
    end

    // Full-width signed product for the current tap
    always_comb begin
        product = PW'(dline[rd_idx]) * PW'(coef[tap]);
    end

    // Optional rounding, arithmetic shift, then saturation to DATA_W
    always_comb begin
        rounded  = SW'(acc) + RND;
        shifted  = rounded >>> FRAC;
        sat_data = DATA_W'(shifted);
        if (shifted > OMAX) begin
            sat_data = DATA_W'(OMAX);
        end else if (shifted < OMIN) begin
            sat_data = DATA_W'(OMIN);
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            wr_ptr    <= '0;
            base      <= '0;
            tap       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A write coincident with a handshake lands before MAC reads it
                    if (coef_we && (AW1'(coef_addr) < AW1'(NTAPS))) begin
                        coef[coef_addr] <= coef_wdata;
                    end
                    if (in_valid && in_ready) begin
                        dline[wr_ptr] <= in_data;
                        base          <= wr_ptr;
                        wr_ptr        <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
                        tap           <= '0;
                        acc           <= '0;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(product);
                    if (tap == AW'(NTAPS - 1)) begin
                        state <= SCALE;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                SCALE: begin
                    out_data  <= sat_data;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_mac.md
FIR_MAC -- requirements
Module: fir_mac

Interface
- REQ-001: Parameter DATA_W, default 16; sample width, signed two's complement.
- REQ-002: Parameter COEF_W, default 16; coefficient width, signed.
- REQ-003: Parameter FRAC, default 14; number of coefficient fraction bits, 1..COEF_W-1.
- REQ-004: Parameter NTAPS, default 8; tap count, 2..32.
- REQ-005: clk  input  1  single clock; all logic SHALL be rising-edge clk.
- REQ-006: reset_n  input  1  reset; synchronous, active-low.
- REQ-007: in_valid  input  1  sample offered.
- REQ-008: in_ready  output  1  block accepts a sample this cycle.
- REQ-009: in_data  input  DATA_W  signed sample x[n].
- REQ-010: coef_we  input  1  coefficient write strobe.
- REQ-011: coef_addr  input  clog2(NTAPS)  tap index k.
- REQ-012: coef_wdata  input  COEF_W  signed coefficient c[k].
- REQ-013: out_valid  output  1  result y[n] available.
- REQ-014: out_ready  input  1  consumer accepts the result.
- REQ-015: out_data  output  DATA_W  signed result y[n].
- REQ-016: busy  output  1  high in every state except IDLE.

Function
- REQ-017: The block SHALL compute y[n] = sum over k=0..NTAPS-1 of c[k]*x[n-k], scaled by 2^-FRAC.
- REQ-018: FSM states SHALL be IDLE, MAC, SCALE, HOLD; reset state is IDLE.
- REQ-019: in_ready SHALL be 1 only in IDLE; a handshake (in_valid && in_ready) SHALL write in_data into a circular delay line as x[n] and enter MAC.
- REQ-020: MAC SHALL take exactly NTAPS cycles, one full-width signed product (DATA_W+COEF_W bits) per cycle, k ascending 0..NTAPS-1.
- REQ-021: The accumulator SHALL be DATA_W+COEF_W+clog2(NTAPS) bits wide and SHALL never overflow internally.
- REQ-022: SCALE (1 cycle) SHALL arithmetic-shift the accumulator right by FRAC, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- REQ-023: HOLD SHALL assert out_valid with out_data stable until out_ready is 1; on that cycle the FSM SHALL return to IDLE.
- REQ-024: Latency: handshake on cycle 0 SHALL yield out_valid on cycle NTAPS+2.
- REQ-025: Maximum throughput SHALL be one sample per NTAPS+3 cycles when out_ready is held at 1.
- REQ-026: Coefficient writes SHALL take effect only in IDLE; a coef_we in any other state SHALL be ignored.
- REQ-027: Delay-line pointer SHALL wrap modulo NTAPS; samples older than NTAPS-1 SHALL be discarded.
- REQ-028: A coef_we coincident with an input handshake in IDLE SHALL be applied before that sample's MAC begins.

Reset
- REQ-029: With reset_n low at a clk edge: FSM -> IDLE, accumulator, delay line, pointer, and all coefficients -> 0.
- REQ-030: Reset outputs: in_ready=1 (after reset deasserts), out_valid=0, out_data=0, busy=0.
- REQ-031: Reset asserted mid-MAC or in HOLD SHALL abort the result; no out_valid SHALL follow.

Configuration
- REQ-032: Macro FIR_MAC_ROUND_EN defined: SCALE SHALL add 2^(FRAC-1) to the accumulator before the shift (round half up), then saturate.
- REQ-033: Macro FIR_MAC_ROUND_EN undefined: SCALE SHALL truncate toward negative infinity (plain arithmetic shift), then saturate.

Verification
- REQ-034: Defaults; c[0]=16384, others 0; input 1000 -> out_data 1000, out_valid exactly 10 cycles after handshake.
- REQ-035: c = {16384, 8192, 4096, 0, ...}; inputs 16384, 0, 0, 0 -> outputs 16384, 8192, 4096, 0.
- REQ-036: All c[k]=32767; input 32767 repeated 8 times -> last out_data 32767; all inputs -32768 -> -32768 (saturation).
- REQ-037: c[0]=1; input 8192 -> 0 (truncate) / 1 (FIR_MAC_ROUND_EN); input -8192 -> -1 / 0.
- REQ-038: out_ready held 0 for 5 cycles in HOLD -> out_data stable, in_ready 0, coef_we ignored; release -> IDLE next cycle.
- REQ-039: reset_n low on MAC cycle 3 -> out_valid never asserts; next sample 500 with c[0]=16384 (rewritten) -> 500, no history.
